chipset_ready_ctrl: RTL and testbench
=====================================

# chipset_ready_ctrl

Parametrised ready/wait-state controller for the chipset. It merges any number of device ready sources into `processor_ready`. It inserts a runtime-programmable number of wait states per I/O or memory command. A stall watchdog forces completion of a hung bus cycle and records the event.

## Interface
Parameters:
- `NUM_READY`, 4: number of active-high ready sources merged.
- `WAIT_W`, 4: width of the wait-state count inputs.
- `TIMEOUT_CYCLES`, 512: maximum cycles spent in STALL before forced completion. Must be ≥2.
- `TCNT_W`, 8: width of the saturating timeout counter.

Ports:
- `clock`  in  1: the only clock; every flop is on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `io_read_n`, `io_write_n`  in  1 each: active-low I/O command strobes.
- `memory_read_n`, `memory_write_n`  in  1 each: active-low memory command strobes.
- `address_enable_n`  in  1: low means the CPU owns the bus; high means a DMA cycle. Commands are ignored while high.
- `ready_in`  in  NUM_READY: per-device ready, active-high; 1 = not holding the cycle.
- `io_wait_states`  in  WAIT_W: wait states for I/O commands.
- `mem_wait_states`  in  WAIT_W: wait states for memory commands.
- `processor_ready`  out  1: registered ready to the CPU.
- `bus_timeout`  out  1: one-cycle pulse on forced completion.
- `timeout_count`  out  TCNT_W: saturating count of timeouts.
- `wait_active`  out  1: high in WAIT or STALL.

## Operation
Definitions:
- `io_cmd` = ~io_read_n | ~io_write_n.
- `mem_cmd` = ~memory_read_n | ~memory_write_n.
- `cmd_active` = (io_cmd | mem_cmd) & ~address_enable_n.
- `all_rdy` = &ready_in.
- `start` = cmd_active & ~cmd_active_q, where `cmd_active_q` is cmd_active registered.

At `start`, N is latched from the wait-state inputs: io_wait_states if io_cmd, else mem_wait_states. I/O takes priority if both strobe types are low together. Wait-state inputs that change mid-cycle have no effect until the next `start`.

States:
- IDLE, ready=1. On `start`:
  - N=0 and all_rdy → DONE.
  - N=0 and ~all_rdy → STALL.
  - N>0 → WAIT with cnt=N.
- WAIT, ready=0.
  - cnt decrements each cycle.
  - At cnt==1: → DONE if all_rdy, else → STALL.
- STALL, ready=0. The watchdog timer clears on entry and increments each cycle.
  - all_rdy → DONE.
  - Timer == TIMEOUT_CYCLES-1 and ~all_rdy → DONE, with `bus_timeout`=1 for exactly one cycle and timeout_count += 1, saturating at all-ones.
  - all_rdy in the timeout cycle wins: no timeout is recorded.
- DONE, ready=1. When cmd_active deasserts → IDLE.

Abort and boundary rules:
- cmd_active deasserts in WAIT or STALL → IDLE; ready returns to 1 the next cycle; no timeout is recorded.
- A new `start` can only follow at least one cycle with cmd_active low.
- Strobes switching between I/O and memory while cmd_active stays high do not generate a new `start`.
- N = 2^WAIT_W-1 is legal; the counter does not wrap.

Reset values:
- IDLE, processor_ready=1, bus_timeout=0, timeout_count=0, wait_active=0, cmd_active_q=0.
- Reset mid-cycle takes precedence over all transitions.
- timeout_count clears only on reset.

## Timing
- All outputs are registered. `processor_ready` = (state==IDLE | state==DONE) and changes one cycle after the causing edge.
- `start` sampled at edge E0 with N>0: ready is low from E0 through E0+N and high from E0+N if all_rdy held. That is exactly N low cycles.
- N=0 with all_rdy at `start`: ready never drops.
- Ready sources are sampled only in WAIT's last cycle and in STALL. A ready_in dip during early WAIT cycles has no effect.
- Maximum ready-low duration = N + TIMEOUT_CYCLES cycles.
- `bus_timeout` is asserted in the same cycle the state enters DONE via timeout.

## Test plan
- Reset with all strobes high → processor_ready=1, timeout_count=0, wait_active=0.
- IO read, io_wait_states=3, ready_in all 1 → processor_ready low exactly 3 cycles after start, then 1 until the strobe releases. Repeat with a memory write and mem_wait_states=0 → ready never drops.
- io_wait_states=1, ready_in[2]=0 for 5 cycles after WAIT ends → ready low for 6 cycles total, no bus_timeout.
- TIMEOUT_CYCLES=8, ready_in[0] stuck 0 → ready low for N+8 cycles, one bus_timeout pulse, timeout_count=1. Run 256 such cycles with TCNT_W=8 → timeout_count holds at 255.
- Strobe released mid-WAIT (N=10, release after 4) → IDLE, ready=1 next cycle, no timeout. Both io and memory strobes low with io_wait_states=2 and mem_wait_states=7 → 2 wait cycles.
- address_enable_n=1 with strobes low → ready stays 1. Reset asserted during STALL → IDLE and ready=1 next cycle, timeout_count cleared.

Source files
------------

// File: rtl/chipset_ready_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// chipset_ready_ctrl : ready merge, programmable wait states, stall watchdog
// Rev 1.0
// ----------------------------------------------------------------------------
module chipset_ready_ctrl #(
   parameter int NUM_READY      = 4,
   parameter int WAIT_W         = 4,
   parameter int TIMEOUT_CYCLES = 512,
   parameter int TCNT_W         = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_read_n,
   input  logic                 io_write_n,
   input  logic                 memory_read_n,
   input  logic                 memory_write_n,
   input  logic                 address_enable_n,
   input  logic [NUM_READY-1:0] ready_in,
   input  logic [WAIT_W-1:0]    io_wait_states,
   input  logic [WAIT_W-1:0]    mem_wait_states,
   output logic                 processor_ready,
   output logic                 bus_timeout,
   output logic [TCNT_W-1:0]    timeout_count,
   output logic                 wait_active
);

   localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_STALL = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state, next_state;
   logic [WAIT_W-1:0]   cnt, next_cnt;
   logic [TMR_W-1:0]    tmr, next_tmr;
   logic                timeout_hit;
   logic                cmd_active_q;

   logic                io_cmd, mem_cmd, cmd_active, all_rdy, start;
   logic [WAIT_W-1:0]   n_sel;

   assign io_cmd     = ~io_read_n | ~io_write_n;
   assign mem_cmd    = ~memory_read_n | ~memory_write_n;
   assign cmd_active = (io_cmd | mem_cmd) & ~address_enable_n;
   assign all_rdy    = &ready_in;
   assign start      = cmd_active & ~cmd_active_q;
   assign n_sel      = io_cmd ? io_wait_states : mem_wait_states;

   always_comb begin
      next_state  = state;
      next_cnt    = cnt;
      next_tmr    = tmr;
      timeout_hit = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (n_sel == '0) begin
                  next_state = all_rdy ? ST_DONE : ST_STALL;
                  next_tmr   = '0;
               end else begin
                  next_state = ST_WAIT;
                  next_cnt   = n_sel;
               end
            end
         end
         ST_WAIT: begin
            // ready sources only matter in the final wait cycle
            if (!cmd_active) begin
               next_state = ST_IDLE;
            end else if (cnt == WAIT_W'(1)) begin
               next_state = all_rdy ? ST_DONE : ST_STALL;
               next_tmr   = '0;
            end else begin
               next_cnt = cnt - WAIT_W'(1);
            end
         end
         ST_STALL: begin
            if (!cmd_active) begin
               next_state = ST_IDLE;
            end else if (all_rdy) begin
               next_state = ST_DONE;
            end else if (tmr == TMR_LAST) begin
               next_state  = ST_DONE;
               timeout_hit = 1'b1;
            end else begin
               next_tmr = tmr + TMR_W'(1);
            end
         end
         ST_DONE: begin
            if (!cmd_active) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         tmr             <= '0;
         cmd_active_q    <= 1'b0;
         processor_ready <= 1'b1;
         bus_timeout     <= 1'b0;
         timeout_count   <= '0;
         wait_active     <= 1'b0;
      end else begin
         state           <= next_state;
         cnt             <= next_cnt;
         tmr             <= next_tmr;
         cmd_active_q    <= cmd_active;
         processor_ready <= (next_state == ST_IDLE) || (next_state == ST_DONE);
         wait_active     <= (next_state == ST_WAIT) || (next_state == ST_STALL);
         bus_timeout     <= timeout_hit;
         if (timeout_hit && (timeout_count != '1))
            timeout_count <= timeout_count + TCNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_chipset_ready_ctrl.sv
`default_nettype none
// Testbench for chipset_ready_ctrl: randomized commands against a
// per-transaction model of the ready-low window and watchdog.
module tb_chipset_ready_ctrl;
   localparam int NR = 4;
   localparam int WW = 4;
   localparam int TO = 8;
   localparam int TW = 8;

   logic            clock = 1'b0;
   logic            reset;
   logic            io_read_n, io_write_n, memory_read_n, memory_write_n;
   logic            address_enable_n;
   logic [NR-1:0]   ready_in;
   logic [WW-1:0]   io_wait_states, mem_wait_states;
   logic            processor_ready, bus_timeout, wait_active;
   logic [TW-1:0]   timeout_count;

   int  vectors    = 0;
   int  miscompares = 0;
   int  exp_tcnt   = 0;
   int  force_bit  = -1;
   bit  swap_ok    = 1'b0;
   bit  rdy_plan [0:63];

   chipset_ready_ctrl #(
      .NUM_READY(NR), .WAIT_W(WW), .TIMEOUT_CYCLES(TO), .TCNT_W(TW)
   ) dut (
      .clock(clock), .reset(reset),
      .io_read_n(io_read_n), .io_write_n(io_write_n),
      .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
      .address_enable_n(address_enable_n), .ready_in(ready_in),
      .io_wait_states(io_wait_states), .mem_wait_states(mem_wait_states),
      .processor_ready(processor_ready), .bus_timeout(bus_timeout),
      .timeout_count(timeout_count), .wait_active(wait_active)
   );

   always #5 clock = ~clock;

   function automatic logic [NR-1:0] mk_ready(input bit v);
      logic [NR-1:0] r;
      if (v) return '1;
      r = NR'($urandom);
      if (force_bit >= 0) r[force_bit] = 1'b0;
      else if (&r) r[$urandom_range(NR-1, 0)] = 1'b0;
      return r;
   endfunction

   // kind: 0 io read, 1 io write, 2 mem read, 3 mem write, 4 io read + mem write
   task automatic set_cmd(input bit active, input int kind);
      io_read_n = 1'b1; io_write_n = 1'b1; memory_read_n = 1'b1; memory_write_n = 1'b1;
      if (active) begin
         case (kind)
            0: io_read_n = 1'b0;
            1: io_write_n = 1'b0;
            2: memory_read_n = 1'b0;
            3: memory_write_n = 1'b0;
            default: begin io_read_n = 1'b0; memory_write_n = 1'b0; end
         endcase
      end
   endtask

   // One command: held for h edges starting at E0, wait count n.
   // Completion is the first edge E0+j, j in [n, n+TO], with all ready high;
   // none found means a timeout at E0+n+TO. An earlier release aborts.
   task automatic run_txn(input int n, input int kind, input int h);
      int  L;
      bit  found, tmo, exp_rdy, exp_bt;
      L = n + TO; found = 1'b0;
      for (int j = n; j <= n + TO; j++)
         if (!found && rdy_plan[j]) begin L = j; found = 1'b1; end
      tmo = !found && (h > L);

      if (kind == 0 || kind == 1 || kind == 4) begin
         io_wait_states = WW'(n); mem_wait_states = WW'($urandom);
      end else begin
         mem_wait_states = WW'(n); io_wait_states = WW'($urandom);
      end
      set_cmd(1'b1, kind);
      ready_in = mk_ready(rdy_plan[0]);

      for (int e = 0; e <= h + 1; e++) begin
         @(negedge clock);
         exp_rdy = !(e < ((h < L) ? h : L));
         exp_bt  = tmo && (e == L);
         if (exp_bt && exp_tcnt < 255) exp_tcnt++;
         vectors++;
         if (processor_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL ready n=%0d h=%0d e=%0d: got %b want %b", n, h, e, processor_ready, exp_rdy);
         end
         vectors++;
         if (wait_active !== !exp_rdy) begin
            miscompares++;
            $display("FAIL wait_active n=%0d h=%0d e=%0d: got %b want %b", n, h, e, wait_active, !exp_rdy);
         end
         vectors++;
         if (bus_timeout !== exp_bt) begin
            miscompares++;
            $display("FAIL bus_timeout n=%0d h=%0d e=%0d: got %b want %b", n, h, e, bus_timeout, exp_bt);
         end
         vectors++;
         if (timeout_count !== TW'(exp_tcnt)) begin
            miscompares++;
            $display("FAIL timeout_count n=%0d e=%0d: got %0d want %0d", n, e, timeout_count, exp_tcnt);
         end
         // late changes to the wait-state inputs must be ignored
         io_wait_states  = WW'($urandom);
         mem_wait_states = WW'($urandom);
         set_cmd(e + 1 < h, swap_ok ? int'($urandom_range(4, 0)) : kind);
         ready_in = mk_ready(rdy_plan[e + 1]);
      end
   endtask

   task automatic plan_all(input bit v);
      for (int j = 0; j < 64; j++) rdy_plan[j] = v;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      address_enable_n = 1'b0;
      set_cmd(1'b0, 0);
      ready_in = '1; io_wait_states = '0; mem_wait_states = '0;
      repeat (2) @(negedge clock);
      vectors++;
      if (processor_ready !== 1'b1) begin miscompares++; $display("FAIL reset ready: got %b want 1", processor_ready); end
      vectors++;
      if (timeout_count !== '0) begin miscompares++; $display("FAIL reset count: got %0d want 0", timeout_count); end
      vectors++;
      if (wait_active !== 1'b0) begin miscompares++; $display("FAIL reset wait_active: got %b want 0", wait_active); end
      vectors++;
      if (bus_timeout !== 1'b0) begin miscompares++; $display("FAIL reset bus_timeout: got %b want 0", bus_timeout); end
      reset = 1'b0;
      exp_tcnt = 0;
      @(negedge clock);
   endtask

   task automatic test_io_wait3;
      plan_all(1'b1);
      run_txn(3, 0, 7);
   endtask

   task automatic test_mem_zero;
      plan_all(1'b1);
      run_txn(0, 3, 4);
   endtask

   task automatic test_stall_release;
      plan_all(1'b1);
      for (int j = 1; j <= 5; j++) rdy_plan[j] = 1'b0;
      force_bit = 2;
      run_txn(1, 0, 9);
      force_bit = -1;
   endtask

   task automatic test_timeout;
      plan_all(1'b0);
      force_bit = 0;
      run_txn(2, 1, 2 + TO + 3);
      force_bit = -1;
   endtask

   task automatic test_abort;
      plan_all(1'b1);
      run_txn(10, 0, 4);
      plan_all(1'b0);
      run_txn(0, 2, 5);
   endtask

   task automatic test_both_strobes;
      plan_all(1'b1);
      run_txn(2, 4, 5);
   endtask

   task automatic test_aen_high;
      address_enable_n = 1'b1;
      set_cmd(1'b1, 4);
      io_wait_states = 4'd5; mem_wait_states = 4'd5;
      ready_in = 4'b0000;
      for (int e = 0; e < 6; e++) begin
         @(negedge clock);
         vectors++;
         if (processor_ready !== 1'b1 || wait_active !== 1'b0) begin
            miscompares++;
            $display("FAIL aen_high e=%0d: ready %b wait %b want 1/0", e, processor_ready, wait_active);
         end
      end
      set_cmd(1'b0, 0);
      @(negedge clock);
      address_enable_n = 1'b0;
      ready_in = '1;
      @(negedge clock);
   endtask

   task automatic test_random;
      swap_ok = 1'b1;
      for (int t = 0; t < 60; t++) begin
         int n, h;
         n = $urandom_range(15, 0);
         h = $urandom_range(30, 1);
         if ($urandom_range(3, 0) == 0) plan_all(1'b0);
         else for (int j = 0; j < 64; j++) rdy_plan[j] = ($urandom_range(9, 0) < 4);
         run_txn(n, $urandom_range(4, 0), h);
      end
      swap_ok = 1'b0;
   endtask

   task automatic test_saturate;
      plan_all(1'b0);
      force_bit = 1;
      for (int k = 0; k < 258; k++) run_txn(0, 2, TO + 2);
      force_bit = -1;
      vectors++;
      if (timeout_count !== 8'd255) begin
         miscompares++;
         $display("FAIL saturate: got %0d want 255", timeout_count);
      end
   endtask

   task automatic test_reset_in_stall;
      io_wait_states = '0;
      set_cmd(1'b1, 0);
      ready_in = 4'b1011;
      repeat (4) @(negedge clock);
      vectors++;
      if (wait_active !== 1'b1 || processor_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_entry: wait %b ready %b want 1/0", wait_active, processor_ready);
      end
      reset = 1'b1;
      @(negedge clock);
      vectors++;
      if (processor_ready !== 1'b1 || wait_active !== 1'b0 || timeout_count !== '0 || bus_timeout !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_in_stall: ready %b wait %b count %0d bt %b want 1/0/0/0",
                  processor_ready, wait_active, timeout_count, bus_timeout);
      end
      exp_tcnt = 0;
      reset = 1'b0;
      set_cmd(1'b0, 0);
      ready_in = '1;
      @(negedge clock);
      plan_all(1'b1);
      run_txn(1, 2, 3);
   endtask

   initial begin
      test_reset();
      test_io_wait3();
      test_mem_zero();
      test_stall_release();
      test_timeout();
      test_abort();
      test_both_strobes();
      test_aen_high();
      test_random();
      test_saturate();
      test_reset_in_stall();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
`default_nettype wire
